jt49_bus_master: RTL and testbench

// Bus initiator for the jt49 PSG register port. Accepts write/read commands through a

---
 rtl/jt49_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_jt49_bus_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : jt49_bus_master
// Description : Command-FIFO bus initiator for the jt49 PSG register port with
//               programmable setup/strobe/recovery timing. Define
//               JT49_BM_SKIPDUP_EN to drop writes that repeat a register value.
// Revision    : 1.0 - initial release
// ============================================================================
module jt49_bus_master #(
    parameter int FIFO_AW = 3,
    parameter int SETUP   = 1,
    parameter int PULSE   = 2,
    parameter int RECOV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [3:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    output logic [3:0] bus_addr,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);

    localparam int c_depth       = 1 << FIFO_AW;
    localparam int c_setup_ticks = (SETUP < 1) ? 1 : SETUP;
    localparam int c_pulse_ticks = (PULSE < 1) ? 1 : PULSE;
    localparam int c_recov_ticks = (RECOV < 1) ? 1 : RECOV;
    localparam logic [15:0] c_setup_last = 16'(c_setup_ticks - 1);
    localparam logic [15:0] c_pulse_last = 16'(c_pulse_ticks - 1);
    localparam logic [15:0] c_recov_last = 16'(c_recov_ticks - 1);
    localparam logic [FIFO_AW:0] c_ptr_one = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_RECOV  = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic             r_rd;
    logic [12:0]      r_mem [c_depth];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_skip;
    logic             w_head_rd;
    logic [3:0]       w_head_addr;
    logic [7:0]       w_head_data;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                       (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = clk_en && (r_state == S_IDLE) && !w_empty;
    assign {w_head_rd, w_head_addr, w_head_data} = r_mem[r_rptr[FIFO_AW-1:0]];
    assign busy      = !w_empty || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= {cmd_rd, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

`ifdef JT49_BM_SKIPDUP_EN
    logic [7:0]  r_shadow [16];
    logic [15:0] r_shadow_vld;
    logic        w_shadow_upd;

    // Register 13 restarts the envelope on every write, so it is never skipped.
    assign w_skip = !w_head_rd && (w_head_addr != 4'd13) &&
                    r_shadow_vld[w_head_addr] &&
                    (r_shadow[w_head_addr] == w_head_data);
    assign w_shadow_upd = w_pop && !w_skip && !w_head_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_vld <= '0;
        end else if (w_shadow_upd) begin
            r_shadow_vld[w_head_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_shadow_upd) begin
            r_shadow[w_head_addr] <= w_head_data;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= 1'b0;
            bus_cs_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_addr  <= '0;
            bus_dout  <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (clk_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_empty && !w_skip) begin
                            bus_addr <= w_head_addr;
                            bus_dout <= w_head_data;
                            bus_cs_n <= 1'b0;
                            r_rd     <= w_head_rd;
                            r_cnt    <= '0;
                            r_state  <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (r_cnt == c_setup_last) begin
                            bus_wr_n <= r_rd;
                            r_cnt    <= '0;
                            r_state  <= S_STROBE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_STROBE: begin
                        if (r_cnt == c_pulse_last) begin
                            if (r_rd) begin
                                rsp_valid <= 1'b1;
                                rsp_addr  <= bus_addr;
                                rsp_data  <= bus_din;
                            end
                            bus_cs_n <= 1'b1;
                            bus_wr_n <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_RECOV;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: begin
                        if (r_cnt == c_recov_last) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt49_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt49_bus_master
// Description : Scoreboard bench for jt49_bus_master (default timing 1/2/2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt49_bus_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rd = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       busy;
    logic       bus_cs_n;
    logic       bus_wr_n;
    logic [3:0] bus_addr;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;

    jt49_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .bus_cs_n  (bus_cs_n),
        .bus_wr_n  (bus_wr_n),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din)
    );

    always #5 clk = ~clk;

    // PSG read model: register n reads back 0x07 + n (so register 8 gives 0x0F).
    assign bus_din = 8'h07 + {4'h0, bus_addr};

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_bus = 0;
    logic [12:0] exp_bus[$];
    logic [11:0] exp_rsp[$];
    logic [7:0]  sh [16];
    logic [15:0] shv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus / response monitor
    logic        in_acc = 1'b0;
    logic        prev_or = 1'b1;
    logic        seen = 1'b0;
    int          cs_cnt, wr_cnt, edges, hi_cnt;
    logic [3:0]  cap_addr;
    logic [7:0]  cap_dout;
    logic [12:0] e;
    logic [11:0] r;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_acc  = 1'b0;
            prev_or = 1'b1;
            seen    = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (!bus_cs_n && !in_acc) begin
                in_acc   = 1'b1;
                cs_cnt   = 0;
                wr_cnt   = 0;
                edges    = 0;
                cap_addr = bus_addr;
                cap_dout = bus_dout;
                if (seen) check("recov_gap_ge2", hi_cnt >= 2, 1'b1);
            end
            if (prev_or && !(bus_cs_n | bus_wr_n)) edges++;
            prev_or = bus_cs_n | bus_wr_n;
            if (!bus_cs_n) begin
                cs_cnt++;
                if (!bus_wr_n) wr_cnt++;
            end else begin
                if (in_acc) begin
                    in_acc = 1'b0;
                    seen   = 1'b1;
                    hi_cnt = 0;
                    n_bus++;
                    if (exp_bus.size() == 0) begin
                        check("bus_access_expected", exp_bus.size() > 0, 1'b1);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_addr", cap_addr, e[11:8]);
                        check("cs_low_clk", cs_cnt, 3);
                        if (!e[12]) begin
                            check("bus_dout", cap_dout, e[7:0]);
                            check("wr_low_clk", wr_cnt, 2);
                            check("wr_fall_edges", edges, 1);
                        end else begin
                            check("rd_wr_low_clk", wr_cnt, 0);
                            check("rd_fall_edges", edges, 0);
                        end
                    end
                end
                hi_cnt++;
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_expected", exp_rsp.size() > 0, 1'b1);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_addr", rsp_addr, r[11:8]);
                    check("rsp_data", rsp_data, r[7:0]);
                end
            end
        end
    end

    task automatic send(input logic rd, input logic [3:0] a, input logic [7:0] d);
        int   t = 0;
        logic skip = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("push_timeout_ready", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
`ifdef JT49_BM_SKIPDUP_EN
        skip = !rd && (a != 4'd13) && shv[a] && (sh[a] == d);
        if (!skip && !rd) begin
            sh[a]  = d;
            shv[a] = 1'b1;
        end
`endif
        if (!skip) exp_bus.push_back({rd, a, d});
        if (rd) exp_rsp.push_back({a, 8'h07 + {4'h0, a}});
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        @(negedge clk);
        #1;
        while ((busy || exp_bus.size() != 0) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_bus_left"}, exp_bus.size(), 0);
        check({tag, "_rsp_left"}, exp_rsp.size(), 0);
    endtask

    initial begin
        int n0;
        int t;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs_n", bus_cs_n, 1'b1);
        check("rst_wr_n", bus_wr_n, 1'b1);
        check("rst_addr", bus_addr, 4'h0);
        check("rst_dout", bus_dout, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_addr", rsp_addr, 4'h0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        rst_n  = 1'b1;
        clk_en = 1'b1;

        send(1'b0, 4'd7, 8'h38);
        wait_drain("wr7");
        send(1'b1, 4'd8, 8'h00);
        wait_drain("rd8");

        // Fill the FIFO with the FSM frozen, then release it.
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 4'(i), 8'h10 + 8'(i));
        @(negedge clk);
        #1;
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        check("frozen_cs_n", bus_cs_n, 1'b1);
        clk_en = 1'b1;
        send(1'b0, 4'd9, 8'h99);
        wait_drain("fill9");

        n0 = n_bus;
        send(1'b0, 4'd13, 8'h0E);
        send(1'b0, 4'd13, 8'h0E);
        wait_drain("env13");
        check("env13_accesses", n_bus - n0, 2);

        n0 = n_bus;
        send(1'b0, 4'd0, 8'h55);
        send(1'b0, 4'd0, 8'h55);
        wait_drain("dup0");
`ifdef JT49_BM_SKIPDUP_EN
        check("dup0_accesses", n_bus - n0, 1);
`else
        check("dup0_accesses", n_bus - n0, 2);
`endif

        for (int i = 0; i < 24; i++)
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        wait_drain("rand");

        // Reset during the strobe of a write, with more commands queued.
        send(1'b0, 4'd3, 8'h11);
        send(1'b0, 4'd4, 8'h22);
        send(1'b1, 4'd5, 8'h00);
        t = 0;
        while (bus_wr_n && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("strobe_reached_wr_n", bus_wr_n, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", bus_cs_n, 1'b1);
        check("abort_wr_n", bus_wr_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        exp_bus.delete();
        exp_rsp.delete();
        shv = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("post_abort_busy", busy, 1'b0);
        check("post_abort_cs_n", bus_cs_n, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
